// File: rtl/clk_tick_pkg.sv
// ---------------------------------------------------------------------------
// clk_tick_pkg
// Shared constants and helpers for the clock-enable generator.
//   CNT_W_DEF : default counter/divisor width (25 bits covers 20 ms at 50 MHz)
//   MAX_CH    : largest supported channel count
//   MAX_W     : widest divisor the helper functions can extract
//   div_of    : pull channel i's divisor out of a packed divisor list
//   div_sane  : map a zero divisor to 1 so every channel always makes progress
// ---------------------------------------------------------------------------
package clk_tick_pkg;

  localparam int CNT_W_DEF = 25;
  localparam int MAX_CH    = 8;
  localparam int MAX_W     = 32;

  // The list is passed zero-extended to the widest possible packing so one
  // function serves every NUM_CH/CNT_W combination.
  function automatic logic [MAX_W-1:0] div_of(input logic [MAX_CH*MAX_W-1:0] list,
                                              input int i, input int w);
    logic [MAX_W-1:0] d;
    d = '0;
    for (int b = 0; b < MAX_W; b++) begin
      if (b < w) d[b] = list[i*w + b];
    end
    return d;
  endfunction

  function automatic logic [MAX_W-1:0] div_sane(input logic [MAX_W-1:0] d);
    return (d == '0) ? MAX_W'(1) : d;
  endfunction

endpackage

// File: rtl/clk_tick_chan.sv
// ---------------------------------------------------------------------------
// clk_tick_chan
// One divider channel: counts source events and emits a one-cycle tick plus a
// square wave that toggles on every tick.
//   clk_i   : system clock
//   rst_i   : synchronous reset (all state to 0)
//   clr_i   : synchronous restart, same effect as rst_i
//   load_i  : a new divisor is being loaded; restart the count, hold sq
//   en_i    : count enable
//   src_i   : source event for this cycle
//   div_i   : divisor, must be non-zero
//   tick_o  : one-cycle strobe every div_i source events
//   sq_o    : square wave, period 2*div_i source events
// ---------------------------------------------------------------------------
module clk_tick_chan
  import clk_tick_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic             en_i,
  input  logic             src_i,
  input  logic [CNT_W-1:0] div_i,
  output logic             tick_o,
  output logic             sq_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             sq_q, sq_d;
  logic [CNT_W-1:0] div_m1;

  assign div_m1 = div_i - CNT_W'(1);

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    sq_d   = sq_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && src_i) begin
      // >= rather than == keeps the counter bounded even if the divisor
      // ever shrinks beneath the running count.
      if (cnt_q >= div_m1) begin
        cnt_d  = '0;
        tick_d = 1'b1;
        sq_d   = ~sq_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
      sq_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign tick_o = tick_q;
  assign sq_o   = sq_q;

endmodule

// File: rtl/clk_tick_gen.sv
// ---------------------------------------------------------------------------
// clk_tick_gen
// Multi-channel clock-enable generator. Every channel divides either CLK or
// (when CASCADE=1) the previous channel's TICK, producing a one-cycle TICK
// strobe and a 50 % SQ wave. Everything stays in the CLK domain.
//   CLK      : system clock
//   RST      : synchronous active-high reset
//   EN       : per-channel count enable
//   CLR      : synchronous restart of all channels (keeps loaded divisors)
//   TICK     : per-channel one-cycle strobe
//   SQ       : per-channel square wave
// Optional (macro CLK_TICK_DIV_LOAD_EN):
//   LOAD     : write LOAD_DIV into channel LOAD_CH's divisor register
//   LOAD_CH  : target channel; values >= NUM_CH are ignored
//   LOAD_DIV : new divisor (0 stored as 1)
// Without the macro, divisors are constants taken from DIV_LIST.
// ---------------------------------------------------------------------------
module clk_tick_gen
  import clk_tick_pkg::*;
#(
  parameter int                        NUM_CH   = 2,
  parameter int                        CNT_W    = CNT_W_DEF,
  parameter logic [NUM_CH*CNT_W-1:0]   DIV_LIST = {25'd2000, 25'd500},
  parameter bit                        CASCADE  = 1'b1,
  localparam int                       LCH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NUM_CH-1:0] EN,
  input  logic              CLR,
`ifdef CLK_TICK_DIV_LOAD_EN
  input  logic              LOAD,
  input  logic [LCH_W-1:0]  LOAD_CH,
  input  logic [CNT_W-1:0]  LOAD_DIV,
`endif
  output logic [NUM_CH-1:0] TICK,
  output logic [NUM_CH-1:0] SQ
);

  localparam logic [MAX_CH*MAX_W-1:0] LIST_EXT = (MAX_CH*MAX_W)'(DIV_LIST);

  logic [NUM_CH-1:0] src;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [MAX_W-1:0] DIV_C = div_sane(div_of(LIST_EXT, gi, CNT_W));

    logic [CNT_W-1:0] div_w;
    logic             load_w;

    // Channel 0 always sees CLK; later channels see the parent's tick when
    // cascaded, so a frozen parent naturally stalls its children.
    if (gi == 0 || !CASCADE) begin : g_src_clk
      assign src[gi] = 1'b1;
    end else begin : g_src_casc
      assign src[gi] = TICK[gi-1];
    end

`ifdef CLK_TICK_DIV_LOAD_EN
    logic [CNT_W-1:0] div_q;

    // Out-of-range LOAD_CH matches no channel, so it is ignored for free.
    assign load_w = LOAD && !CLR && (int'(LOAD_CH) == gi);

    always_ff @(posedge CLK) begin
      if (RST) begin
        div_q <= DIV_C[CNT_W-1:0];
      end else if (load_w) begin
        div_q <= (LOAD_DIV == '0) ? CNT_W'(1) : LOAD_DIV;
      end
    end

    assign div_w = div_q;
`else
    assign load_w = 1'b0;
    assign div_w  = DIV_C[CNT_W-1:0];
`endif

    clk_tick_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk_i  (CLK),
      .rst_i  (RST),
      .clr_i  (CLR),
      .load_i (load_w),
      .en_i   (EN[gi]),
      .src_i  (src[gi]),
      .div_i  (div_w),
      .tick_o (TICK[gi]),
      .sq_o   (SQ[gi])
    );
  end

endmodule

// File: tb/tb_clk_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_gen
// Three generator instances share CLK/RST/EN/CLR:
//   u_casc : DIV0=5, DIV1=3, cascaded
//   u_ind  : DIV0=5, DIV1=3, independent channels
//   u_one  : DIV0=1, DIV1=0 (treated as 1), cascaded
// Edge numbering: edge 1 is the first edge sampled with RST low.
// ---------------------------------------------------------------------------
module tb_clk_tick_gen;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [1:0] en;
  logic [1:0] tick_c, sq_c, tick_i, sq_i, tick_o1, sq_o1;

  int n_checks = 0;
  int n_errors = 0;
  int e = 0;

`ifdef CLK_TICK_DIV_LOAD_EN
  logic         load;
  logic         ld_ch;
  logic [W-1:0] ld_div;
`endif

  always #10 clk = ~clk;

  clk_tick_gen #(.NUM_CH(2), .CNT_W(W), .DIV_LIST({8'd3, 8'd5}), .CASCADE(1'b1)) u_casc (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr),
`ifdef CLK_TICK_DIV_LOAD_EN
    .LOAD(load), .LOAD_CH(ld_ch), .LOAD_DIV(ld_div),
`endif
    .TICK(tick_c), .SQ(sq_c));

  clk_tick_gen #(.NUM_CH(2), .CNT_W(W), .DIV_LIST({8'd3, 8'd5}), .CASCADE(1'b0)) u_ind (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr),
`ifdef CLK_TICK_DIV_LOAD_EN
    .LOAD(1'b0), .LOAD_CH(1'b0), .LOAD_DIV(8'd0),
`endif
    .TICK(tick_i), .SQ(sq_i));

  clk_tick_gen #(.NUM_CH(2), .CNT_W(W), .DIV_LIST({8'd0, 8'd1}), .CASCADE(1'b1)) u_one (
    .CLK(clk), .RST(rst), .EN(en), .CLR(clr),
`ifdef CLK_TICK_DIV_LOAD_EN
    .LOAD(1'b0), .LOAD_CH(1'b0), .LOAD_DIV(8'd0),
`endif
    .TICK(tick_o1), .SQ(sq_o1));

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s edge=%0d got=%b expected=%b", tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    e++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clr = 1'b0;
    en  = 2'b11;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    e   = 0;
  endtask

  initial begin
`ifdef CLK_TICK_DIV_LOAD_EN
    load   = 1'b0;
    ld_ch  = 1'b0;
    ld_div = '0;
`endif
    // ---- free run from reset ----
    do_reset();
    check("rst_tick_c", |tick_c, 1'b0);
    check("rst_sq_c",   |sq_c,   1'b0);
    check("rst_tick_i", |tick_i, 1'b0);
    check("rst_tick_o", |tick_o1, 1'b0);
    check("rst_sq_o",   |sq_o1,  1'b0);
    for (int k = 1; k <= 32; k++) begin
      step();
      check("c_tick0", tick_c[0], (e % 5) == 0);
      check("c_sq0",   sq_c[0],   ((e / 5) % 2) == 1);
      check("c_tick1", tick_c[1], (e == 16) || (e == 31));
      check("c_sq1",   sq_c[1],   (e >= 16) && (e < 31));
      check("i_tick0", tick_i[0], (e % 5) == 0);
      check("i_tick1", tick_i[1], (e % 3) == 0);
      check("i_sq1",   sq_i[1],   ((e / 3) % 2) == 1);
      check("o_tick0", tick_o1[0], 1'b1);
      check("o_sq0",   sq_o1[0],  (e % 2) == 1);
      check("o_tick1", tick_o1[1], e >= 2);
      check("o_sq1",   sq_o1[1],  ((e - 1) % 2) == 1);
    end
    $display("phase free_run done at edge %0d, errors so far %0d", e, n_errors);

    // ---- EN[0] low during edges 3..7 ----
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      step();
      check("en_tick0", tick_c[0], e == 10);
      check("en_sq0",   sq_c[0],   e >= 10);
      check("en_o_tick0", tick_o1[0], !((e >= 3) && (e <= 7)));
      if (e == 2) en = 2'b10;
      if (e == 7) en = 2'b11;
    end
    $display("phase enable_freeze done at edge %0d, errors so far %0d", e, n_errors);

    // ---- CLR (mode 0) or RST (mode 1) sampled at edge 7 ----
    for (int mode = 0; mode < 2; mode++) begin
      do_reset();
      for (int k = 1; k <= 14; k++) begin
        step();
        check(mode == 0 ? "clr_tick0" : "mrst_tick0", tick_c[0], (e == 5) || (e == 12));
        check(mode == 0 ? "clr_sq0" : "mrst_sq0", sq_c[0], ((e >= 5) && (e < 7)) || (e >= 12));
        check(mode == 0 ? "clr_i_tick1" : "mrst_i_tick1", tick_i[1],
              (e == 3) || (e == 6) || (e == 10) || (e == 13));
        if (e == 6) begin
          if (mode == 0) clr = 1'b1;
          else           rst = 1'b1;
        end
        if (e == 7) begin
          clr = 1'b0;
          rst = 1'b0;
        end
      end
      $display("phase restart mode=%0d done at edge %0d, errors so far %0d", mode, e, n_errors);
    end

`ifdef CLK_TICK_DIV_LOAD_EN
    // ---- load DIV0=2 sampled at edge 4 ----
    do_reset();
    for (int k = 1; k <= 10; k++) begin
      step();
      check("ld_tick0", tick_c[0], (e == 6) || (e == 8) || (e == 10));
      if (e == 3) begin
        load   = 1'b1;
        ld_ch  = 1'b0;
        ld_div = 8'd2;
      end
      if (e == 4) load = 1'b0;
    end
    $display("phase load done at edge %0d, errors so far %0d", e, n_errors);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
